controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameter: WIDTH, 16, instruction and datapath word width.
REQ-002 Parameter: IMM, 8, immediate field width passed to the datapath sign extender.
REQ-003 Ports, in order:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr  in  WIDTH  fetched instruction word from memory; [15:12] opcode, [11:8] Rdest/cond, [7:4] opext, [3:0] Rsrc, [7:0] imm.
- mem_ready  in  1  memory read data valid / write accepted this cycle.
- flag_z  in  1  zero flag from the last compare.
- flag_n  in  1  negative flag from the last compare.
- irwrite  out  1  latch instr into the instruction register.
- pcen  out  1  PC register enable.
- pc_s  out  1  0=Rsrc, 1=alu_out.
- mem_s  out  1  0=Rdest address, 1=PC address.
- mem_we  out  1  memory write strobe.
- wd_s  out  2  00=imm, 01=Rsrc, 10=mem_out, 11=alu_out.
- alua_s  out  2  00=Rsrc, 01=PC, 10=imm_ext.
- alub_s  out  2  00=Rdest, 01=imm_ext, 10=constant one.
- sign_ext_s  out  1  1=sign-extend imm, 0=zero-extend.
- regwrite  out  1  register file write enable.
- alucont  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
- busy  out  1  high in every state except FETCH.

Function
REQ-004 States: FETCH, DECODE, EXEC_R, EXEC_I, LOAD_RD, LOAD_WB, STORE, BRANCH, JUMP.
REQ-005 FETCH: mem_s=1, alua_s=01, alub_s=10, alucont=ADD, pc_s=1. Stay in FETCH while mem_ready=0; when mem_ready=1, assert irwrite=1 and pcen=1 in that cycle and go to DECODE.
REQ-006 DECODE: one cycle, no enables asserted. Branch by opcode:
- 0000 -> EXEC_R.
- 0101/1001/0001/0010/0011/1101 -> EXEC_I.
- 0100 with opext 0000 -> LOAD_RD; opext 0100 -> STORE; opext 1100 -> JUMP.
- 1100 -> BRANCH.
- Anything else -> FETCH (NOP).
REQ-007 EXEC_R: opext 0101 ADD, 1001 SUB, 0001 AND, 0010 OR, 0011 XOR use alua_s=00, alub_s=00, wd_s=11, regwrite=1. Opext 1101 MOV uses wd_s=01, regwrite=1. Undefined opext sets regwrite=0. Next state is FETCH.
REQ-008 EXEC_I: ALU ops use alub_s=01, wd_s=11. ADDI and SUBI take sign_ext_s=1; logical ops take sign_ext_s=0. MOVI uses wd_s=00. regwrite=1; next state is FETCH.
REQ-009 LOAD_RD: mem_s=0; hold while mem_ready=0; go to LOAD_WB on mem_ready=1.
REQ-010 LOAD_WB: wd_s=10, regwrite=1; next state is FETCH.
REQ-011 STORE: mem_s=0, mem_we=1; hold mem_we until mem_ready=1, then go to FETCH.
REQ-012 BRANCH: condition in [11:8]: 0000 EQ (Z), 0001 NE (!Z), 0110 LT (N), 1110 always; other codes are never taken.
- Taken: alua_s=01, alub_s=01, sign_ext_s=1, alucont=ADD, pc_s=1, pcen=1, giving target = PC+1+sext(imm).
- Not taken: pcen=0.
- Next state is FETCH.
REQ-013 JUMP: pc_s=0, pcen=1, using the same condition rules as REQ-012; next state is FETCH.
REQ-014 Every output not named for a state SHALL be 0 in that state; outputs are a function of state, instr, flags and mem_ready only.
REQ-015 Instruction latency with mem_ready tied high: ALU/MOV/branch/jump/store 3 cycles; load 4 cycles.
REQ-016 mem_ready=1 arriving in DECODE, EXEC_*, BRANCH or JUMP SHALL be ignored.
REQ-017 At most one of regwrite and mem_we SHALL be high in any cycle.

Reset
REQ-018 reset=1 SHALL force state=FETCH immediately, without waiting for clk; all outputs take their FETCH values (irwrite, pcen, mem_we, regwrite = 0 while reset is high).
REQ-019 Reset asserted mid-LOAD_RD or mid-STORE SHALL abandon the access; after deassertion the first cycle is FETCH.

Structure
REQ-020 Package controller_pkg SHALL hold the state enum, opcode/opext constants, alucont codes, mux-select codes and condition codes.
REQ-021 One combinational sub-module, instr_decode, SHALL map instr to instruction class, alucont, sign_ext_s and the condition-taken bit; the FSM stays in controller.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- ADD R1,R2 (0x0152) with mem_ready=1 -> FETCH, DECODE, EXEC_R; regwrite=1, wd_s=11, alucont=000 in cycle 3.
- ADDI 0xFF (0x51FF) -> EXEC_I with sign_ext_s=1, alub_s=01; ANDI 0x11FF -> sign_ext_s=0.
- LOAD (0x4102) with mem_ready low for 3 cycles in LOAD_RD -> stays in LOAD_RD 4 cycles, then LOAD_WB with wd_s=10, regwrite=1.
- BEQ (0xC005): flag_z=1 -> pcen=1, pc_s=1 in BRANCH; flag_z=0 -> pcen=0.
- Undefined opcode 0xF000 -> DECODE then FETCH; regwrite=0, mem_we=0 throughout.
- Reset pulsed during STORE with mem_ready=0 -> mem_we drops asynchronously; FETCH after release.

Source files
------------

// File: rtl/controller_pkg.sv
// controller_pkg: shared types and encodings for the multi-cycle controller.
// Holds the FSM state enum, the decoded instruction class, opcode/opext
// values, ALU operation codes, datapath mux-select codes and branch/jump
// condition codes.
package controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_LOAD_RD,
        S_LOAD_WB,
        S_STORE,
        S_BRANCH,
        S_JUMP
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_ALU_R,
        CLS_MOV_R,
        CLS_BAD_R,
        CLS_ALU_I,
        CLS_MOV_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP
    } iclass_t;

    // Opcode values; the R-type opext field reuses the ALU/MOV values.
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_MOV   = 4'b1101;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_BCOND = 4'b1100;

    // opext values under OP_MEM
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STORE = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    localparam logic       PC_RSRC   = 1'b0;
    localparam logic       PC_ALU    = 1'b1;
    localparam logic       MEM_RDEST = 1'b0;
    localparam logic       MEM_PC    = 1'b1;

    localparam logic [1:0] WD_IMM  = 2'b00;
    localparam logic [1:0] WD_RSRC = 2'b01;
    localparam logic [1:0] WD_MEM  = 2'b10;
    localparam logic [1:0] WD_ALU  = 2'b11;

    localparam logic [1:0] ALUA_RSRC = 2'b00;
    localparam logic [1:0] ALUA_PC   = 2'b01;
    localparam logic [1:0] ALUA_IMM  = 2'b10;

    localparam logic [1:0] ALUB_RDEST = 2'b00;
    localparam logic [1:0] ALUB_IMM   = 2'b01;
    localparam logic [1:0] ALUB_ONE   = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_LT = 4'b0110;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic       valid;
        logic [2:0] op;
    } alu_sel_t;

    // Maps an ALU opcode/opext value to its ALU operation.
    function automatic alu_sel_t alu_map(input logic [3:0] code);
        alu_sel_t s;
        s.valid = 1'b1;
        s.op    = ALU_ADD;
        case (code)
            OP_ADD:  s.op = ALU_ADD;
            OP_SUB:  s.op = ALU_SUB;
            OP_AND:  s.op = ALU_AND;
            OP_OR:   s.op = ALU_OR;
            OP_XOR:  s.op = ALU_XOR;
            default: s.valid = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/controller_instr_decode.sv
// instr_decode: combinational instruction decoder.
// Ports: opcode/cond/opext fields in, flag_z/flag_n in;
//        iclass (instruction class), alucont, sign_ext_s (immediate ALU ops)
//        and taken (condition in cond satisfied by the flags) out.
module instr_decode
    import controller_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] cond,
    input  logic [3:0] opext,
    input  logic       flag_z,
    input  logic       flag_n,
    output iclass_t    iclass,
    output logic [2:0] alucont,
    output logic       sign_ext_s,
    output logic       taken
);

    alu_sel_t r_alu;
    alu_sel_t i_alu;

    always_comb begin
        r_alu      = alu_map(opext);
        i_alu      = alu_map(opcode);
        iclass     = CLS_NOP;
        alucont    = ALU_ADD;
        sign_ext_s = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                if (r_alu.valid) begin
                    iclass  = CLS_ALU_R;
                    alucont = r_alu.op;
                end else if (opext == OP_MOV) begin
                    iclass = CLS_MOV_R;
                end else begin
                    iclass = CLS_BAD_R;
                end
            end
            OP_MEM: begin
                case (opext)
                    EXT_LOAD:  iclass = CLS_LOAD;
                    EXT_STORE: iclass = CLS_STORE;
                    EXT_JCOND: iclass = CLS_JUMP;
                    default:   iclass = CLS_NOP;
                endcase
            end
            OP_BCOND: iclass = CLS_BRANCH;
            OP_MOV:   iclass = CLS_MOV_I;
            default: begin
                if (i_alu.valid) begin
                    iclass     = CLS_ALU_I;
                    alucont    = i_alu.op;
                    // arithmetic immediates are signed, logical ones are not
                    sign_ext_s = (opcode == OP_ADD) || (opcode == OP_SUB);
                end
            end
        endcase
    end

    always_comb begin
        case (cond)
            COND_EQ: taken = flag_z;
            COND_NE: taken = ~flag_z;
            COND_LT: taken = flag_n;
            COND_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/controller.sv
// controller: multi-cycle FSM controller for a 16-bit datapath.
// Inputs : clk, reset (async, active-high), instr (fetched word), mem_ready,
//          flag_z/flag_n (last compare).
// Outputs: irwrite, pcen, pc_s, mem_s, mem_we, wd_s, alua_s, alub_s,
//          sign_ext_s, regwrite, alucont (datapath controls), busy (not FETCH).
module controller
    import controller_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IMM   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr,
    input  logic             mem_ready,
    input  logic             flag_z,
    input  logic             flag_n,
    output logic             irwrite,
    output logic             pcen,
    output logic             pc_s,
    output logic             mem_s,
    output logic             mem_we,
    output logic [1:0]       wd_s,
    output logic [1:0]       alua_s,
    output logic [1:0]       alub_s,
    output logic             sign_ext_s,
    output logic             regwrite,
    output logic [2:0]       alucont,
    output logic             busy
);

    // IMM sizes the datapath sign extender; Rsrc bits are datapath-only.
    localparam int unsigned imm_w_unused = IMM;
    logic [WIDTH-1:0] unused_instr_bits;
    assign unused_instr_bits = instr;

    state_t     state, next_state;
    iclass_t    dec_class;
    logic [2:0] dec_alucont;
    logic       dec_sext;
    logic       dec_taken;

    instr_decode u_decode (
        .opcode     (instr[15:12]),
        .cond       (instr[11:8]),
        .opext      (instr[7:4]),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .iclass     (dec_class),
        .alucont    (dec_alucont),
        .sign_ext_s (dec_sext),
        .taken      (dec_taken)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        pc_s       = PC_RSRC;
        mem_s      = MEM_RDEST;
        mem_we     = 1'b0;
        wd_s       = WD_IMM;
        alua_s     = ALUA_RSRC;
        alub_s     = ALUB_RDEST;
        sign_ext_s = 1'b0;
        regwrite   = 1'b0;
        alucont    = ALU_ADD;
        busy       = (state != S_FETCH);

        case (state)
            S_FETCH: begin
                mem_s  = MEM_PC;
                alua_s = ALUA_PC;
                alub_s = ALUB_ONE;
                pc_s   = PC_ALU;
                // reset forces FETCH but must not let a ready memory load IR/PC
                irwrite = mem_ready & ~reset;
                pcen    = mem_ready & ~reset;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                case (dec_class)
                    CLS_ALU_R, CLS_MOV_R, CLS_BAD_R: next_state = S_EXEC_R;
                    CLS_ALU_I, CLS_MOV_I:            next_state = S_EXEC_I;
                    CLS_LOAD:                        next_state = S_LOAD_RD;
                    CLS_STORE:                       next_state = S_STORE;
                    CLS_JUMP:                        next_state = S_JUMP;
                    CLS_BRANCH:                      next_state = S_BRANCH;
                    default:                         next_state = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                next_state = S_FETCH;
                if (dec_class == CLS_ALU_R) begin
                    wd_s     = WD_ALU;
                    regwrite = 1'b1;
                    alucont  = dec_alucont;
                end else if (dec_class == CLS_MOV_R) begin
                    wd_s     = WD_RSRC;
                    regwrite = 1'b1;
                end
            end
            S_EXEC_I: begin
                next_state = S_FETCH;
                if (dec_class == CLS_ALU_I) begin
                    alub_s     = ALUB_IMM;
                    wd_s       = WD_ALU;
                    sign_ext_s = dec_sext;
                    alucont    = dec_alucont;
                    regwrite   = 1'b1;
                end else if (dec_class == CLS_MOV_I) begin
                    wd_s     = WD_IMM;
                    regwrite = 1'b1;
                end
            end
            S_LOAD_RD: begin
                if (mem_ready) next_state = S_LOAD_WB;
            end
            S_LOAD_WB: begin
                wd_s       = WD_MEM;
                regwrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_STORE: begin
                mem_we = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_BRANCH: begin
                next_state = S_FETCH;
                if (dec_taken) begin
                    alua_s     = ALUA_PC;
                    alub_s     = ALUB_IMM;
                    sign_ext_s = 1'b1;
                    alucont    = ALU_ADD;
                    pc_s       = PC_ALU;
                    pcen       = 1'b1;
                end
            end
            S_JUMP: begin
                next_state = S_FETCH;
                pc_s       = PC_RSRC;
                pcen       = dec_taken;
            end
            default: next_state = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_controller.sv
// tb_controller: self-checking bench for controller. Each instruction is
// expanded by a behavioural model into the per-cycle list of expected
// control vectors and the mem_ready values to drive, then played cycle by
// cycle against the DUT.
module tb_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        mem_ready;
    logic        flag_z;
    logic        flag_n;
    logic        irwrite, pcen, pc_s, mem_s, mem_we, sign_ext_s, regwrite, busy;
    logic [1:0]  wd_s, alua_s, alub_s;
    logic [2:0]  alucont;

    int checks = 0;
    int passed = 0;

    logic [3:0] alu_ops [6] = '{4'h5, 4'h9, 4'h1, 4'h2, 4'h3, 4'hD};
    logic [3:0] conds   [4] = '{4'h0, 4'h1, 4'h6, 4'hE};

    controller #(.WIDTH(16), .IMM(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .pc_s       (pc_s),
        .mem_s      (mem_s),
        .mem_we     (mem_we),
        .wd_s       (wd_s),
        .alua_s     (alua_s),
        .alub_s     (alub_s),
        .sign_ext_s (sign_ext_s),
        .regwrite   (regwrite),
        .alucont    (alucont),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Vector order: irwrite pcen pc_s mem_s mem_we wd_s alua_s alub_s sign_ext_s regwrite alucont busy
    logic [16:0] obs;
    assign obs = {irwrite, pcen, pc_s, mem_s, mem_we, wd_s, alua_s, alub_s,
                  sign_ext_s, regwrite, alucont, busy};

    function automatic logic [16:0] v(input logic irw, input logic pce, input logic pcs,
                                      input logic ms, input logic we, input logic [1:0] wd,
                                      input logic [1:0] aa, input logic [1:0] ab,
                                      input logic se, input logic rw, input logic [2:0] alu,
                                      input logic bsy);
        return {irw, pce, pcs, ms, we, wd, aa, ab, se, rw, alu, bsy};
    endfunction

    function automatic logic [16:0] fetch_vec(input logic acc);
        return v(acc, acc, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 3'b000, 1'b0);
    endfunction

    function automatic logic [16:0] idle_vec();
        return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b1);
    endfunction

    // ALU operation table: -1 means "not an ALU operation"
    function automatic int alu_of(input logic [3:0] c);
        case (c)
            4'h5:    return 0;
            4'h9:    return 1;
            4'h1:    return 2;
            4'h2:    return 3;
            4'h3:    return 4;
            default: return -1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [16:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        checks++;
        assert (!(regwrite === 1'b1 && mem_we === 1'b1)) passed++;
        else $error("FAIL %s_excl observed regwrite=%b mem_we=%b expected not both high",
                    tag, regwrite, mem_we);
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the instruction.
    task automatic run_instr(input logic [15:0] ins, input logic z, input logic n,
                             input int fw, input int mw, input string tag);
        logic [16:0] eq[$];
        logic        mq[$];
        logic [3:0]  op, cnd, ext;
        logic        tk;
        int          a;
        logic [2:0]  ac;
        op  = ins[15:12];
        cnd = ins[11:8];
        ext = ins[7:4];
        tk  = (cnd == 4'h0 && z) || (cnd == 4'h1 && !z) || (cnd == 4'h6 && n) || (cnd == 4'hE);

        for (int i = 0; i < fw; i++) begin
            eq.push_back(fetch_vec(1'b0)); mq.push_back(1'b0);
        end
        eq.push_back(fetch_vec(1'b1)); mq.push_back(1'b1);
        eq.push_back(idle_vec()); mq.push_back(1'($urandom_range(0, 1)));

        if (op == 4'h0) begin
            a = alu_of(ext);
            ac = a[2:0];
            if (a >= 0)
                eq.push_back(v(0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 1, ac, 1));
            else if (ext == 4'hD)
                eq.push_back(v(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 1, 3'b000, 1));
            else
                eq.push_back(idle_vec());
            mq.push_back(1'($urandom_range(0, 1)));
        end else if (op == 4'hD) begin
            eq.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 3'b000, 1));
            mq.push_back(1'($urandom_range(0, 1)));
        end else if (alu_of(op) >= 0) begin
            a = alu_of(op);
            ac = a[2:0];
            eq.push_back(v(0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b01,
                           (op == 4'h5 || op == 4'h9), 1, ac, 1));
            mq.push_back(1'($urandom_range(0, 1)));
        end else if (op == 4'h4 && ext == 4'h0) begin
            for (int i = 0; i < mw; i++) begin
                eq.push_back(idle_vec()); mq.push_back(1'b0);
            end
            eq.push_back(idle_vec()); mq.push_back(1'b1);
            eq.push_back(v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0, 1, 3'b000, 1));
            mq.push_back(1'($urandom_range(0, 1)));
        end else if (op == 4'h4 && ext == 4'h4) begin
            for (int i = 0; i < mw; i++) begin
                eq.push_back(v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 3'b000, 1));
                mq.push_back(1'b0);
            end
            eq.push_back(v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 3'b000, 1));
            mq.push_back(1'b1);
        end else if (op == 4'h4 && ext == 4'hC) begin
            eq.push_back(v(0, tk, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 3'b000, 1));
            mq.push_back(1'($urandom_range(0, 1)));
        end else if (op == 4'hC) begin
            if (tk) eq.push_back(v(0, 1, 1, 0, 0, 2'b00, 2'b01, 2'b01, 1, 0, 3'b000, 1));
            else    eq.push_back(idle_vec());
            mq.push_back(1'($urandom_range(0, 1)));
        end

        instr  = ins;
        flag_z = z;
        flag_n = n;
        for (int k = 0; k < eq.size(); k++) begin
            mem_ready = mq[k];
            #1;
            check($sformatf("%s_c%0d", tag, k), eq[k]);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [15:0] ri;
        int          kind;
        reset     = 1'b1;
        instr     = 16'h0000;
        mem_ready = 1'b1;
        flag_z    = 1'b0;
        flag_n    = 1'b0;
        #3;
        check("reset_state", fetch_vec(1'b0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // directed scenarios
        run_instr(16'h0152, 0, 0, 0, 0, "add_r");
        run_instr(16'h51FF, 0, 0, 0, 0, "addi");
        run_instr(16'h11FF, 0, 0, 1, 0, "andi");
        run_instr(16'h4102, 0, 0, 0, 3, "load_wait");
        run_instr(16'hC005, 1, 0, 0, 0, "beq_taken");
        run_instr(16'hC005, 0, 0, 0, 0, "beq_not");
        run_instr(16'hF000, 0, 0, 0, 0, "undef");
        run_instr(16'h0FD3, 0, 0, 0, 0, "mov_r");
        run_instr(16'h0E73, 0, 0, 0, 0, "bad_ext");
        run_instr(16'h4EC3, 0, 0, 0, 0, "jump_al");
        run_instr(16'h46C3, 0, 0, 0, 0, "jump_lt_not");
        run_instr(16'h4140, 0, 0, 0, 2, "store_wait");

        // reset during STORE with memory stalled
        instr     = 16'h4140;
        mem_ready = 1'b1;
        #1; check("rst_st_fetch", fetch_vec(1'b1));
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #1; check("rst_st_decode", idle_vec());
        @(posedge clk); #1;
        #1; check("rst_st_store", v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 3'b000, 1));
        #2;
        reset = 1'b1;
        #1; check("rst_st_async", fetch_vec(1'b0));
        mem_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_st_hold", fetch_vec(1'b0));
        reset = 1'b0;
        run_instr(16'h0293, 0, 0, 0, 0, "after_rst");

        // randomized instruction stream
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 6);
            ri   = 16'($urandom);
            case (kind)
                0: ri[15:12] = 4'h0;
                1: ri[15:12] = alu_ops[$urandom_range(0, 5)];
                2: begin ri[15:12] = 4'h4; ri[7:4] = 4'h0; end
                3: begin ri[15:12] = 4'h4; ri[7:4] = 4'h4; end
                4: begin ri[15:12] = 4'h4; ri[7:4] = 4'hC; end
                5: ri[15:12] = 4'hC;
                default: ;
            endcase
            if (kind == 0 && $urandom_range(0, 3) != 0) ri[7:4] = alu_ops[$urandom_range(0, 5)];
            if ((kind == 4 || kind == 5) && $urandom_range(0, 3) != 0)
                ri[11:8] = conds[$urandom_range(0, 3)];
            run_instr(ri, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 3),
                      $sformatf("rnd%0d_%h", t, ri));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
